// File: rtl/bitrev_pingpong_ctrl.sv
// Ping-pong frame scheduler for the bit-reversal reorder buffer: tracks which of
// two 32-row banks is being filled or drained and emits row/bank/enable strobes.
module bitrev_pingpong_ctrl #(
  parameter  int TOTAL_SIZE   = 512,
  parameter  int DATA_PER_CLK = 16,
  localparam int ROWS         = TOTAL_SIZE / DATA_PER_CLK,
  localparam int ROW_W        = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             in_ready,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [ROW_W-1:0] wr_row,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [ROW_W-1:0] rd_row,
  output logic             valid_out,
  input  logic             out_ready,
  output logic             frame_last_out,
  output logic [1:0]       bank_full,
  output logic             overflow_err
);

  typedef enum logic {WR_FILL, WR_WAIT}   wr_state_e;
  typedef enum logic {RD_IDLE, RD_ACTIVE} rd_state_e;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  wr_state_e        wr_state_q, wr_state_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             valid_out_q, valid_out_d;
  logic             frame_last_q, frame_last_d;
  logic             overflow_q, overflow_d;

  logic             wr_last, rd_last;
  logic [1:0]       set_vec, clr_vec;

  assign in_ready = (wr_state_q == WR_FILL) && !rst;
  assign wr_en    = valid_in && in_ready;
  assign rd_en    = (rd_state_q == RD_ACTIVE) && (!valid_out_q || out_ready) && !rst;

  assign wr_last  = wr_en && (wr_row_q == LAST_ROW);
  assign rd_last  = rd_en && (rd_row_q == LAST_ROW);

  // A bank completed and a bank released in the same cycle are always different banks.
  assign set_vec     = wr_last ? (2'b01 << wr_bank_q) : 2'b00;
  assign clr_vec     = rd_last ? (2'b01 << rd_bank_q) : 2'b00;
  assign bank_full_d = (bank_full_q | set_vec) & ~clr_vec;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_state_d   = wr_state_q;
    rd_state_d   = rd_state_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_row_d     = wr_row_q;
    rd_row_d     = rd_row_q;
    valid_out_d  = valid_out_q;
    frame_last_d = frame_last_q;
    overflow_d   = overflow_q | (valid_in && !in_ready);

    if (wr_en) begin
      wr_row_d = wr_last ? '0 : wr_row_q + 1'b1;
    end

    // Looking at next-cycle fullness lets a bank released this cycle be written next cycle.
    unique case (wr_state_q)
      WR_FILL: if (wr_last) begin
        wr_bank_d = ~wr_bank_q;
        if (bank_full_d[~wr_bank_q]) wr_state_d = WR_WAIT;
      end
      WR_WAIT: if (!bank_full_d[wr_bank_q]) wr_state_d = WR_FILL;
      default: wr_state_d = WR_FILL;
    endcase

    unique case (rd_state_q)
      RD_IDLE:   if (bank_full_d[rd_bank_q]) rd_state_d = RD_ACTIVE;
      RD_ACTIVE: if (rd_last) begin
        rd_state_d = RD_IDLE;
        rd_bank_d  = ~rd_bank_q;
      end
      default:   rd_state_d = RD_IDLE;
    endcase

    if (rd_en) begin
      rd_row_d     = rd_last ? '0 : rd_row_q + 1'b1;
      valid_out_d  = 1'b1;
      frame_last_d = rd_last;
    end else if (out_ready) begin
      valid_out_d  = 1'b0;
      frame_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_state_q   <= WR_FILL;
      rd_state_q   <= RD_IDLE;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_row_q     <= '0;
      rd_row_q     <= '0;
      bank_full_q  <= 2'b00;
      valid_out_q  <= 1'b0;
      frame_last_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_row_q     <= wr_row_d;
      rd_row_q     <= rd_row_d;
      bank_full_q  <= bank_full_d;
      valid_out_q  <= valid_out_d;
      frame_last_q <= frame_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_bank        = wr_bank_q;
  assign wr_row         = wr_row_q;
  assign rd_bank        = rd_bank_q;
  assign rd_row         = rd_row_q;
  assign valid_out      = valid_out_q;
  assign frame_last_out = frame_last_q;
  assign bank_full      = bank_full_q;
  assign overflow_err   = overflow_q;

  a_no_set_clr_same_bank: assert property (@(posedge clk) disable iff (rst)
    (set_vec & clr_vec) == 2'b00);

endmodule

// File: tb/tb_bitrev_pingpong_ctrl.sv
// Directed bench for bitrev_pingpong_ctrl: fill/drain, ping-pong, backpressure,
// overflow, mid-frame reset and WR_WAIT release timing.
module tb_bitrev_pingpong_ctrl;

  logic       clk = 1'b0;
  logic       rst, valid_in, out_ready;
  logic       in_ready, wr_en, wr_bank, rd_en, rd_bank;
  logic       valid_out, frame_last_out, overflow_err;
  logic [4:0] wr_row, rd_row;
  logic [1:0] bank_full;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc_cnt = 0;
  int exp_row, exp_bank, exp_wr_row, exp_wr_bank;
  int beats, lasts, last_err, order_err, rd_cnt, wr_err, ir_err;
  int starts [3];
  int n_starts;
  int c0, rel, rise;
  logic rise_wr_ok;

  bitrev_pingpong_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .in_ready       (in_ready),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_row         (wr_row),
    .rd_en          (rd_en),
    .rd_bank        (rd_bank),
    .rd_row         (rd_row),
    .valid_out      (valid_out),
    .out_ready      (out_ready),
    .frame_last_out (frame_last_out),
    .bank_full      (bank_full),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
  endtask

  task automatic model_init();
    exp_row = 0; exp_bank = 0; exp_wr_row = 0; exp_wr_bank = 0;
    beats = 0; lasts = 0; last_err = 0; order_err = 0; rd_cnt = 0;
    wr_err = 0; ir_err = 0; n_starts = 0;
    for (int i = 0; i < 3; i++) starts[i] = -1000;
  endtask

  // Reference reader order and output beat accounting.
  task automatic observe();
    if (rd_en) begin
      rd_cnt++;
      if (int'(rd_row) != exp_row || int'(rd_bank) != exp_bank) order_err++;
      if (rd_row == 5'd0 && n_starts < 3) begin
        starts[n_starts] = cyc_cnt;
        n_starts++;
      end
      if (exp_row == 31) begin
        exp_row  = 0;
        exp_bank = 1 - exp_bank;
      end else begin
        exp_row++;
      end
    end
    if (valid_out && out_ready) begin
      beats++;
      if (frame_last_out) begin
        lasts++;
        if (beats % 32 != 0) last_err++;
      end
    end
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      #1;
      if (!in_ready) ir_err++;
      else begin
        if (int'(wr_row) != exp_wr_row || int'(wr_bank) != exp_wr_bank || !wr_en) wr_err++;
        if (exp_wr_row == 31) begin
          exp_wr_row  = 0;
          exp_wr_bank = 1 - exp_wr_bank;
        end else begin
          exp_wr_row++;
        end
      end
      observe();
      cyc();
    end
  endtask

  task automatic run(input int n, input bit toggle);
    repeat (n) begin
      if (toggle) out_ready = ~out_ready;
      #1;
      observe();
      cyc();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    model_init();
  endtask

  initial begin
    // ---- Test 1: reset values, single frame ----
    rst = 1'b1; valid_in = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_rows", {wr_row, rd_row}, 0);
    check("rst_banks", {wr_bank, rd_bank}, 0);
    check("rst_valid_last_ovf", {valid_out, frame_last_out, overflow_err}, 0);
    rst = 1'b0;
    cyc();
    model_init();
    c0 = cyc_cnt;
    send(32);
    check("t1_wr_seq", wr_err, 0);
    valid_in = 1'b0;
    #1;
    check("t1_rd_en_T1", rd_en, 1);
    check("t1_rd_row_T1", rd_row, 0);
    check("t1_bank_full", bank_full, 2'b01);
    check("t1_wr_bank_toggled", wr_bank, 1);
    check("t1_valid_out_T1", valid_out, 0);
    observe();
    cyc();
    #1;
    check("t1_valid_out_T2", valid_out, 1);
    run(40, 1'b0);
    check("t1_first_rd_latency", starts[0] - c0, 32);
    check("t1_beats", beats, 32);
    check("t1_lasts", lasts, 1);
    check("t1_last_pos", last_err, 0);
    check("t1_order", order_err, 0);
    check("t1_rd_bank_end", rd_bank, 1);
    check("t1_bank_full_end", bank_full, 0);

    // ---- Test 2: three back-to-back frames ----
    do_reset();
    c0 = cyc_cnt;
    send(96);
    valid_in = 1'b0;
    run(80, 1'b0);
    check("t2_in_ready_held", ir_err, 0);
    check("t2_wr_seq", wr_err, 0);
    check("t2_beats", beats, 96);
    check("t2_lasts", lasts, 3);
    check("t2_last_pos", last_err, 0);
    check("t2_order", order_err, 0);
    check("t2_first_start", starts[0] - c0, 32);
    check("t2_bubble_1", starts[1] - starts[0], 33);
    check("t2_bubble_2", starts[2] - starts[1], 33);

    // ---- Test 3: backpressure fills both banks, then overflow ----
    do_reset();
    out_ready = 1'b0;
    send(64);
    check("t3_in_ready_64", ir_err, 0);
    check("t3_wr_seq", wr_err, 0);
    valid_in = 1'b1;
    #1;
    check("t3_in_ready_low", in_ready, 0);
    check("t3_wr_en_low", wr_en, 0);
    check("t3_bank_full", bank_full, 2'b11);
    observe();
    cyc();
    valid_in = 1'b0;
    #1;
    check("t3_overflow", overflow_err, 1);
    check("t3_wr_ptr_frozen", {wr_bank, wr_row}, 0);
    observe();
    cyc(); cyc(); cyc();
    #1;
    check("t3_valid_hold", valid_out, 1);
    check("t3_rd_row_frozen", rd_row, 1);
    check("t3_rd_en_stalled", rd_en, 0);
    check("t3_no_last", frame_last_out, 0);

    // ---- Test 4: drain under toggling out_ready ----
    run(200, 1'b1);
    check("t4_beats", beats, 64);
    check("t4_rd_cnt", rd_cnt, 64);
    check("t4_lasts", lasts, 2);
    check("t4_last_pos", last_err, 0);
    check("t4_order", order_err, 0);
    check("t4_bank_full_end", bank_full, 0);
    check("t4_overflow_sticky", overflow_err, 1);

    // ---- Test 6: WR_WAIT release timing ----
    do_reset();
    out_ready = 1'b0;
    send(64);
    valid_in = 1'b1;
    #1;
    check("t6_waiting", in_ready, 0);
    observe();
    cyc();
    rel = -1; rise = -1; rise_wr_ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'b1; valid_in = 1'b1;
      #1;
      if (rd_en && rd_bank == 1'b0 && rd_row == 5'd31 && rel < 0) rel = cyc_cnt;
      if (in_ready && rise < 0) begin
        rise = cyc_cnt;
        rise_wr_ok = wr_en && (wr_bank == 1'b0) && (wr_row == 5'd0);
      end
      observe();
      cyc();
    end
    valid_in = 1'b0;
    check("t6_last_rd_seen", rel >= 0, 1);
    check("t6_release_delay", rise - rel, 1);
    check("t6_write_bank0_row0", rise_wr_ok, 1);

    // ---- Test 5: reset mid-frame, then clean frame ----
    do_reset();
    send(20);
    rst = 1'b1; valid_in = 1'b0;
    #1;
    check("t5_rst_in_ready", in_ready, 0);
    check("t5_rst_wr_en", wr_en, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("t5_wr_row_cleared", wr_row, 0);
    check("t5_state_cleared", {bank_full, wr_bank, rd_bank, valid_out, frame_last_out, overflow_err}, 0);
    check("t5_rd_en", rd_en, 0);
    model_init();
    send(32);
    valid_in = 1'b0;
    run(45, 1'b0);
    check("t5_wr_seq", wr_err, 0);
    check("t5_beats", beats, 32);
    check("t5_lasts", lasts, 1);
    check("t5_last_pos", last_err, 0);
    check("t5_order", order_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
